// File: rtl/call_stack_pkg.sv
// Shared types and constants for the return-address stack controller.
// Holds the FSM state enum, fault codes and default sizing.
package call_stack_pkg;

  localparam int ADDR_W_DEF     = 11;
  localparam int DEPTH_LOG2_DEF = 7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH     = 3'd1,
    ST_POP      = 3'd2,
    ST_POP_WAIT = 3'd3,
    ST_LOAD     = 3'd4,
    ST_FLUSH    = 3'd5,
    ST_FAULT    = 3'd6
  } state_t;

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_OVF  = 2'b01;
  localparam logic [1:0] FC_UNF  = 2'b10;
  localparam logic [1:0] FC_ILL  = 2'b11;

endpackage

// File: rtl/call_stack_ctrl.sv
// CALL/RET sequencer for the return-address stack: turns decoder requests into
// push/pop/clear strobes and PC loads, tracking occupancy to block over/underflow.
module call_stack_ctrl
  import call_stack_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  call_req,
  input  logic                  ret_req,
  input  logic                  flush_req,
  input  logic [ADDR_W-1:0]     ret_addr,
  input  logic [ADDR_W-1:0]     target_addr,
  input  logic [ADDR_W-1:0]     stk_topo,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic                  stk_rst,
  output logic [ADDR_W-1:0]     stk_dado,
  output logic                  pc_load,
  output logic [ADDR_W-1:0]     pc_next,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic [1:0]            fault_code,
  output logic [DEPTH_LOG2:0]   level,
  input  logic                  fault_clr
);

  localparam int                LVL_W   = DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0]  DEPTH_V = LVL_W'(1) << DEPTH_LOG2;

  state_t              state_r;
  state_t              next_state_s;
  logic [1:0]          new_code_s;
  logic                accept_call_s;

  logic                stk_push_r;
  logic                stk_pop_r;
  logic                stk_rst_r;
  logic                pc_load_r;
  logic                done_r;
  logic                fault_r;
  logic [1:0]          fault_code_r;
  logic [ADDR_W-1:0]   stk_dado_r;
  logic [ADDR_W-1:0]   target_r;
  logic [ADDR_W-1:0]   pc_next_r;
  logic [LVL_W-1:0]    level_r;

  // Next-state decode; IDLE priority is illegal call+ret, then call, ret, flush.
  always_comb begin
    next_state_s  = state_r;
    new_code_s    = FC_NONE;
    accept_call_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (call_req && ret_req) begin
          next_state_s = ST_FAULT;
          new_code_s   = FC_ILL;
        end else if (call_req) begin
          if (level_r == DEPTH_V) begin
            next_state_s = ST_FAULT;
            new_code_s   = FC_OVF;
          end else begin
            next_state_s  = ST_PUSH;
            accept_call_s = 1'b1;
          end
        end else if (ret_req) begin
          if (level_r == {LVL_W{1'b0}}) begin
            next_state_s = ST_FAULT;
            new_code_s   = FC_UNF;
          end else begin
            next_state_s = ST_POP;
          end
        end else if (flush_req) begin
          next_state_s = ST_FLUSH;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_PUSH:     next_state_s = ST_LOAD;
      ST_POP:      next_state_s = ST_POP_WAIT;
      ST_POP_WAIT: next_state_s = ST_LOAD;
      ST_LOAD:     next_state_s = ST_IDLE;
      ST_FLUSH:    next_state_s = ST_IDLE;
      ST_FAULT: begin
        if (fault_clr) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_FAULT;
        end
      end
      default:     next_state_s = ST_IDLE;
    endcase
  end

  // State register; strobes are registered from the next state so each lands
  // in the same cycle as the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      stk_push_r <= 1'b0;
      stk_pop_r  <= 1'b0;
      stk_rst_r  <= 1'b0;
      pc_load_r  <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      stk_push_r <= (next_state_s == ST_PUSH);
      stk_pop_r  <= (next_state_s == ST_POP);
      stk_rst_r  <= (next_state_s == ST_FLUSH);
      pc_load_r  <= (next_state_s == ST_LOAD);
      done_r     <= (next_state_s == ST_LOAD) || (next_state_s == ST_FLUSH);
    end
  end

  // Address path: push data and pending target latched on an accepted CALL,
  // PC taken from the target (CALL) or from the stack top (RET).
  always_ff @(posedge clk) begin
    if (reset) begin
      stk_dado_r <= {ADDR_W{1'b0}};
      target_r   <= {ADDR_W{1'b0}};
      pc_next_r  <= {ADDR_W{1'b0}};
    end else begin
      if (accept_call_s) begin
        stk_dado_r <= ret_addr;
        target_r   <= target_addr;
      end
      if (state_r == ST_PUSH) begin
        pc_next_r <= target_r;
      end else if (state_r == ST_POP_WAIT) begin
        pc_next_r <= stk_topo;
      end
    end
  end

  // Shadow occupancy; only reachable transitions are guarded, so no wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_r <= {LVL_W{1'b0}};
    end else begin
      case (state_r)
        ST_PUSH:  level_r <= level_r + LVL_W'(1);
        ST_POP:   level_r <= level_r - LVL_W'(1);
        ST_FLUSH: level_r <= {LVL_W{1'b0}};
        default:  level_r <= level_r;
      endcase
    end
  end

  // Sticky fault flag and code, set on entry to FAULT and cleared on exit.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_r      <= 1'b0;
      fault_code_r <= FC_NONE;
    end else if (state_r != ST_FAULT && next_state_s == ST_FAULT) begin
      fault_r      <= 1'b1;
      fault_code_r <= new_code_s;
    end else if (state_r == ST_FAULT && fault_clr) begin
      fault_r      <= 1'b0;
      fault_code_r <= FC_NONE;
    end
  end

  assign stk_push   = stk_push_r;
  assign stk_pop    = stk_pop_r;
  assign stk_rst    = stk_rst_r;
  assign stk_dado   = stk_dado_r;
  assign pc_load    = pc_load_r;
  assign pc_next    = pc_next_r;
  assign done       = done_r;
  assign fault      = fault_r;
  assign fault_code = fault_code_r;
  assign level      = level_r;
  assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Self-checking bench for call_stack_ctrl: directed scenarios plus random ops,
// checked against a queue-based model of the return stack.
module tb_call_stack_ctrl;

  localparam int AW    = 11;
  localparam int DL    = 7;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          reset, call_req, ret_req, flush_req, fault_clr;
  logic [AW-1:0] ret_addr, target_addr, stk_topo;
  logic          stk_push, stk_pop, stk_rst, pc_load, busy, done, fault;
  logic [AW-1:0] stk_dado, pc_next;
  logic [1:0]    fault_code;
  logic [DL:0]   level;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] ref_q[$];
  logic [AW-1:0] stk_mem[$];

  call_stack_ctrl #(.ADDR_W(AW), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset(reset), .call_req(call_req), .ret_req(ret_req),
    .flush_req(flush_req), .ret_addr(ret_addr), .target_addr(target_addr),
    .stk_topo(stk_topo), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_rst(stk_rst), .stk_dado(stk_dado), .pc_load(pc_load),
    .pc_next(pc_next), .busy(busy), .done(done), .fault(fault),
    .fault_code(fault_code), .level(level), .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  // The stack device itself: top is presented the cycle after a pop.
  always @(posedge clk) begin
    if (reset) begin
      stk_mem.delete();
      stk_topo <= '0;
    end else begin
      if (stk_push) stk_mem.push_back(stk_dado);
      if (stk_pop) begin
        if (stk_mem.size() > 0) stk_topo <= stk_mem.pop_back();
        else stk_topo <= 11'h7FF;
      end
      if (stk_rst) stk_mem.delete();
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    call_req = 1'b0; ret_req = 1'b0; flush_req = 1'b0; fault_clr = 1'b0;
  endtask

  task automatic junk_inputs();
    call_req  = 1'($urandom_range(0, 1));
    ret_req   = 1'($urandom_range(0, 1));
    flush_req = 1'($urandom_range(0, 1));
  endtask

  // Called at the first negedge after a faulting request was sampled.
  task automatic expect_fault(input logic [1:0] code, input int lvl);
    chk("fault_set", fault, 1);
    chk("fault_code", fault_code, code);
    chk("fault_busy", busy, 1);
    chk("fault_nostrobe", {stk_push, stk_pop, stk_rst, pc_load}, 0);
    chk("fault_level", level, lvl);
    call_req = 1'b1; ret_req = 1'($urandom_range(0, 1));
    @(negedge clk);
    idle_inputs();
    chk("fault_ignore_strobe", {stk_push, stk_pop, stk_rst, pc_load}, 0);
    chk("fault_ignore_busy", busy, 1);
    chk("fault_ignore_code", fault_code, code);
    chk("fault_ignore_level", level, lvl);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("fault_clr_flag", fault, 0);
    chk("fault_clr_code", fault_code, 0);
    chk("fault_clr_idle", busy, 0);
    chk("fault_clr_level", level, lvl);
  endtask

  task automatic do_call(input logic [AW-1:0] ra, input logic [AW-1:0] ta);
    int lvl;
    lvl = ref_q.size();
    call_req = 1'b1; ret_addr = ra; target_addr = ta;
    @(negedge clk);
    idle_inputs();
    ret_addr = AW'($urandom); target_addr = AW'($urandom);
    if (lvl == DEPTH) begin
      expect_fault(2'b01, lvl);
    end else begin
      chk("call_push", stk_push, 1);
      chk("call_dado", stk_dado, ra);
      chk("call_early_load", pc_load, 0);
      junk_inputs();
      @(negedge clk);
      idle_inputs();
      chk("call_load", pc_load, 1);
      chk("call_done", done, 1);
      chk("call_pc", pc_next, ta);
      chk("call_push_once", stk_push, 0);
      ref_q.push_back(ra);
      @(negedge clk);
      chk("call_idle", busy, 0);
      chk("call_done_once", {pc_load, done}, 0);
      chk("call_level", level, ref_q.size());
    end
  endtask

  task automatic do_ret();
    int lvl;
    logic [AW-1:0] exp_pc;
    lvl = ref_q.size();
    ret_req = 1'b1;
    @(negedge clk);
    idle_inputs();
    if (lvl == 0) begin
      expect_fault(2'b10, 0);
    end else begin
      chk("ret_pop", stk_pop, 1);
      chk("ret_early_load", pc_load, 0);
      junk_inputs();
      @(negedge clk);
      idle_inputs();
      chk("ret_wait_load", pc_load, 0);
      chk("ret_pop_once", stk_pop, 0);
      @(negedge clk);
      exp_pc = ref_q.pop_back();
      chk("ret_load", pc_load, 1);
      chk("ret_done", done, 1);
      chk("ret_pc", pc_next, exp_pc);
      @(negedge clk);
      chk("ret_idle", busy, 0);
      chk("ret_level", level, ref_q.size());
    end
  endtask

  task automatic do_ill();
    int lvl;
    lvl = ref_q.size();
    call_req = 1'b1; ret_req = 1'b1;
    @(negedge clk);
    idle_inputs();
    expect_fault(2'b11, lvl);
  endtask

  task automatic do_flush();
    flush_req = 1'b1;
    @(negedge clk);
    idle_inputs();
    chk("flush_rst", stk_rst, 1);
    chk("flush_done", done, 1);
    chk("flush_noload", {stk_push, stk_pop, pc_load}, 0);
    ref_q.delete();
    @(negedge clk);
    chk("flush_level", level, 0);
    chk("flush_idle", busy, 0);
    chk("flush_once", stk_rst, 0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1; ret_addr = '0; target_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {stk_push, stk_pop, stk_rst, pc_load, done, fault, busy}, 0);
    chk("rst_code", fault_code, 0);
    chk("rst_level", level, 0);
    chk("rst_dado", stk_dado, 0);
    chk("rst_pc", pc_next, 0);
    reset = 1'b0;
    @(negedge clk);

    do_call(11'h005, 11'h100);
    do_ret();

    for (int i = 0; i < DEPTH; i++) do_call(AW'($urandom), AW'($urandom));
    chk("full_level", level, DEPTH);
    do_call(11'h123, 11'h456);
    do_flush();

    do_ret();
    do_call(11'h0AA, 11'h0BB);
    do_ill();

    do_call(11'h001, 11'h011);
    do_call(11'h002, 11'h022);
    chk("pre_flush_level", level, 3);
    do_flush();

    do_call(11'h3F0, 11'h200);
    do_call(11'h3F1, 11'h201);
    ret_req = 1'b1;
    @(negedge clk);
    ret_req = 1'b0;
    chk("rstmid_pop", stk_pop, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_q.delete();
    chk("rstmid_noload", {pc_load, done}, 0);
    chk("rstmid_idle", busy, 0);
    chk("rstmid_level", level, 0);
    @(negedge clk);
    chk("rstmid_noload_late", pc_load, 0);

    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_call(AW'($urandom), AW'($urandom));
        4, 5, 6:    do_ret();
        7:          do_flush();
        8:          do_ill();
        default:    @(negedge clk);
      endcase
    end
    chk("final_level", level, ref_q.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/call_stack_ctrl.md
Name: call_stack_ctrl

Overview:
Sequences the processor's return-address stack for CALL and RET instructions. It sits between the instruction decoder and the stack/PC datapath. It converts single-cycle decoder requests into stack push/pop pulses and PC load commands. It also keeps a shadow occupancy count and blocks overflow and underflow before they corrupt the stack.

Parameters:
ADDR_W, 11, width of PC / return address
DEPTH_LOG2, 7, log2 of stack depth (DEPTH = 1 << DEPTH_LOG2 = 128)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
call_req  in  1  decoder CALL request, sampled only when busy=0
ret_req  in  1  decoder RET request, sampled only when busy=0
flush_req  in  1  empty the stack, sampled only when busy=0
ret_addr  in  ADDR_W  return address to save (PC+1), sampled with call_req
target_addr  in  ADDR_W  CALL destination, sampled with call_req
stk_topo  in  ADDR_W  stack top value, valid the cycle after stk_pop
stk_push  out  1  one-cycle push strobe to stack
stk_pop  out  1  one-cycle pop strobe to stack
stk_rst  out  1  one-cycle stack pointer clear
stk_dado  out  ADDR_W  data to push
pc_load  out  1  one-cycle PC load strobe
pc_next  out  ADDR_W  PC value, valid while pc_load=1
busy  out  1  controller not in IDLE
done  out  1  one-cycle completion pulse, coincident with pc_load or flush completion
fault  out  1  sticky error
fault_code  out  2  01 overflow, 10 underflow, 11 simultaneous call+ret
level  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH
fault_clr  in  1  clears fault, returns to IDLE

Behaviour:
- Reset: state IDLE. level=0. fault=0, fault_code=00. All strobes 0. stk_dado=0, pc_next=0.
- States: IDLE, PUSH, POP, POP_WAIT, LOAD, FLUSH, FAULT.
- IDLE, call_req=1, ret_req=0:
  - level==DEPTH -> FAULT, fault_code=01.
  - Otherwise latch ret_addr into stk_dado and target_addr into the pending target -> PUSH.
- PUSH: stk_push=1 for exactly one cycle; level+1 -> LOAD with pc_next=target.
- IDLE, ret_req=1, call_req=0:
  - level==0 -> FAULT, fault_code=10.
  - Otherwise -> POP.
- POP: stk_pop=1 for one cycle; level-1 -> POP_WAIT.
- POP_WAIT: capture stk_topo into pc_next -> LOAD.
- LOAD: pc_load=1 and done=1 for one cycle -> IDLE.
- Latency from request cycle N:
  - CALL: stk_push at N+1; pc_load and done at N+2.
  - RET: stk_pop at N+1; pc_load and done at N+3.
- IDLE, call_req & ret_req -> FAULT, fault_code=11. No stack strobe.
- flush_req in IDLE, with no call/ret -> FLUSH: stk_rst=1 and done=1 for one cycle, level=0 -> IDLE.
- Priority in IDLE: simultaneous call/ret fault > call > ret > flush.
- FAULT: busy=1, no strobes, level frozen. fault_clr=1 clears fault and fault_code next cycle -> IDLE. Requests are ignored while in FAULT.
- Requests while busy=1 are dropped, not queued. The decoder must stall on busy.
- At most one of stk_push/stk_pop/stk_rst is high in any cycle.
- level never wraps: it saturates by construction via the overflow/underflow checks.
- busy is a combinational function of state (state != IDLE). All other outputs are registered.
- reset mid-operation: returns to IDLE within one cycle. Any in-flight pc_load is discarded. The stack itself is reset by the same global reset.

Decomposition:
- Shared package `call_stack_pkg` holds:
  - the state enum;
  - fault code constants FC_NONE=00, FC_OVF=01, FC_UNF=10, FC_ILL=11;
  - default ADDR_W and DEPTH_LOG2.
- No sub-module. The FSM and level counter live in one module; the level counter is inline.

Test Plan:
- Reset, then CALL with ret_addr=0x005, target=0x100 -> stk_push at N+1 with stk_dado=0x005; pc_load at N+2 with pc_next=0x100; level=1.
- After the CALL above, RET with stk_topo=0x005 returned -> stk_pop at N+1; pc_load at N+3 with pc_next=0x005; level=0.
- 128 CALLs, then a 129th -> fault=1, fault_code=01, no stk_push, level=128; fault_clr -> IDLE, fault=0.
- RET at level=0 -> fault_code=10, no stk_pop; call_req during FAULT ignored.
- call_req and ret_req high in the same cycle -> fault_code=11; level unchanged.
- level=3, flush_req -> stk_rst pulse and done next cycle, level=0; reset asserted during POP_WAIT -> IDLE, no pc_load, level=0.
